// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter sharing one L2 request/response port between the I-side (0) and
// D-side (1) L1 caches, with per-requester read credits and source-tagged fill routing.
module l2_req_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORDS           = 8,
  parameter int unsigned MSHR_ID_BITS    = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_BITS        = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          rq0_addr_i,
  input  logic [DATA_WIDTH*WORDS-1:0]    rq0_data_i,
  input  logic                           rq0_rw_i,
  input  logic                           rq0_valid_i,
  input  logic [MSHR_ID_BITS-1:0]        rq0_id_i,
  output logic                           rq0_stall_o,
  output logic [DATA_WIDTH*WORDS-1:0]    rq0_data_o,
  output logic                           rq0_valid_o,
  output logic [MSHR_ID_BITS-1:0]        rq0_id_o,
  input  logic [ADDR_WIDTH-1:0]          rq1_addr_i,
  input  logic [DATA_WIDTH*WORDS-1:0]    rq1_data_i,
  input  logic                           rq1_rw_i,
  input  logic                           rq1_valid_i,
  input  logic [MSHR_ID_BITS-1:0]        rq1_id_i,
  output logic                           rq1_stall_o,
  output logic [DATA_WIDTH*WORDS-1:0]    rq1_data_o,
  output logic                           rq1_valid_o,
  output logic [MSHR_ID_BITS-1:0]        rq1_id_o,
  output logic [ADDR_WIDTH-1:0]          l2_addr_o,
  output logic [DATA_WIDTH*WORDS-1:0]    l2_data_o,
  output logic                           l2_rw_o,
  output logic                           l2_valid_o,
  output logic [MSHR_ID_BITS:0]          l2_id_o,
  input  logic                           l2_stall_i,
  input  logic [DATA_WIDTH*WORDS-1:0]    l2_data_i,
  input  logic                           l2_valid_i,
  input  logic [MSHR_ID_BITS:0]          l2_id_i,
  output logic                           err_o
);

  localparam int unsigned LineW = DATA_WIDTH * WORDS;
  localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(MAX_OUTSTANDING);

  logic                    l2_valid_q, l2_valid_d;
  logic [ADDR_WIDTH-1:0]   l2_addr_q, l2_addr_d;
  logic [LineW-1:0]        l2_data_q, l2_data_d;
  logic                    l2_rw_q, l2_rw_d;
  logic [MSHR_ID_BITS:0]   l2_id_q, l2_id_d;
  logic                    rr_q, rr_d;
  logic [CNT_BITS-1:0]     cnt_q [2];
  logic [CNT_BITS-1:0]     cnt_d [2];
  logic                    err_q, err_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic [LineW-1:0]        rsp_data_q [2];
  logic [LineW-1:0]        rsp_data_d [2];
  logic [MSHR_ID_BITS-1:0] rsp_id_q [2];
  logic [MSHR_ID_BITS-1:0] rsp_id_d [2];

  logic       can_load;
  logic [1:0] elig, gnt, req_rw, rsp_hit;

  assign can_load = ~l2_valid_q | ~l2_stall_i;
  assign req_rw   = {rq1_rw_i, rq0_rw_i};
  assign elig[0]  = rq0_valid_i & (rq0_rw_i | (cnt_q[0] < CntMax));
  assign elig[1]  = rq1_valid_i & (rq1_rw_i | (cnt_q[1] < CntMax));
  assign rsp_hit  = {l2_valid_i & l2_id_i[MSHR_ID_BITS], l2_valid_i & ~l2_id_i[MSHR_ID_BITS]};

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (can_load) begin
      if (elig == 2'b11) gnt = rr_q ? 2'b01 : 2'b10;
      else               gnt = elig;
    end
  end

  assign rq0_stall_o = ~gnt[0];
  assign rq1_stall_o = ~gnt[1];

  always_comb begin
    l2_valid_d = l2_valid_q;
    l2_addr_d  = l2_addr_q;
    l2_data_d  = l2_data_q;
    l2_rw_d    = l2_rw_q;
    l2_id_d    = l2_id_q;
    rr_d       = rr_q;
    if (gnt != 2'b00) begin
      l2_valid_d = 1'b1;
      l2_addr_d  = gnt[1] ? rq1_addr_i : rq0_addr_i;
      l2_data_d  = gnt[1] ? rq1_data_i : rq0_data_i;
      l2_rw_d    = gnt[1] ? rq1_rw_i : rq0_rw_i;
      l2_id_d    = gnt[1] ? {1'b1, rq1_id_i} : {1'b0, rq0_id_i};
      rr_d       = gnt[1];
    end else if (l2_valid_q && !l2_stall_i) begin
      l2_valid_d = 1'b0;
    end
  end

  // Credits and fill routing; a grant and a fill for the same source cancel out.
  always_comb begin
    err_d       = err_q;
    rsp_valid_d = rsp_hit;
    for (int n = 0; n < 2; n++) begin
      cnt_d[n]      = cnt_q[n];
      rsp_data_d[n] = rsp_data_q[n];
      rsp_id_d[n]   = rsp_id_q[n];
      if (rsp_hit[n]) begin
        rsp_data_d[n] = l2_data_i;
        rsp_id_d[n]   = l2_id_i[MSHR_ID_BITS-1:0];
        if (cnt_q[n] == '0) err_d = 1'b1;
      end
      if (gnt[n] && !req_rw[n] && !rsp_hit[n]) begin
        cnt_d[n] = cnt_q[n] + CNT_BITS'(1);
      end else if (rsp_hit[n] && !(gnt[n] && !req_rw[n]) && cnt_q[n] != '0) begin
        cnt_d[n] = cnt_q[n] - CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l2_valid_q  <= 1'b0;
      l2_addr_q   <= '0;
      l2_data_q   <= '0;
      l2_rw_q     <= 1'b0;
      l2_id_q     <= '0;
      rr_q        <= 1'b1;
      err_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        cnt_q[n]      <= '0;
        rsp_data_q[n] <= '0;
        rsp_id_q[n]   <= '0;
      end
    end else begin
      l2_valid_q  <= l2_valid_d;
      l2_addr_q   <= l2_addr_d;
      l2_data_q   <= l2_data_d;
      l2_rw_q     <= l2_rw_d;
      l2_id_q     <= l2_id_d;
      rr_q        <= rr_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      for (int n = 0; n < 2; n++) begin
        cnt_q[n]      <= cnt_d[n];
        rsp_data_q[n] <= rsp_data_d[n];
        rsp_id_q[n]   <= rsp_id_d[n];
      end
    end
  end

  assign l2_valid_o  = l2_valid_q;
  assign l2_addr_o   = l2_addr_q;
  assign l2_data_o   = l2_data_q;
  assign l2_rw_o     = l2_rw_q;
  assign l2_id_o     = l2_id_q;
  assign err_o       = err_q;
  assign rq0_valid_o = rsp_valid_q[0];
  assign rq1_valid_o = rsp_valid_q[1];
  assign rq0_data_o  = rsp_data_q[0];
  assign rq1_data_o  = rsp_data_q[1];
  assign rq0_id_o    = rsp_id_q[0];
  assign rq1_id_o    = rsp_id_q[1];

endmodule
